// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction encodings, queue occupancy states and helpers for the snake heading controller
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    // Heading the snake starts with out of reset
    localparam dir_t DIR_RESET = DIR_RIGHT;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_TWO   = 2'd2
    } q_state_t;

    // Same axis (bit1) but other sense (bit0) means a 180-degree turn
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_cmd_fifo2.sv
// rtl/snake_cmd_fifo2.sv - two-entry direction command queue with simultaneous push and pop
module snake_cmd_fifo2
    import snake_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic [1:0] count
);

    q_state_t state;
    q_state_t state_nxt;
    dir_t     entry0;
    dir_t     entry1;

    // Occupancy state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= Q_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy next state; push and pop together leave occupancy unchanged
    always_comb begin
        state_nxt = state;
        case (state)
            Q_EMPTY: if (push)         state_nxt = Q_ONE;
            Q_ONE: begin
                if (push && !pop)      state_nxt = Q_TWO;
                else if (pop && !push) state_nxt = Q_EMPTY;
            end
            Q_TWO:   if (pop && !push) state_nxt = Q_ONE;
            default:                   state_nxt = Q_EMPTY;
        endcase
    end

    // Occupancy count and tail selection derived from the state
    always_comb begin
        count = 2'd0;
        tail  = entry0;
        case (state)
            Q_ONE:   count = 2'd1;
            Q_TWO: begin
                count = 2'd2;
                tail  = entry1;
            end
            default: count = 2'd0;
        endcase
    end

    assign head = entry0;

    // Entry storage; entry0 is always the head, a pop shifts entry1 forward
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            entry0 <= DIR_UP;
            entry1 <= DIR_UP;
        end else begin
            case (state)
                Q_EMPTY: begin
                    if (push) entry0 <= push_data;
                end
                Q_ONE: begin
                    if (push && pop) entry0 <= push_data;
                    else if (push)   entry1 <= push_data;
                end
                Q_TWO: begin
                    if (pop) begin
                        entry0 <= entry1;
                        if (push) entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - snake heading controller; define SNAKE_REVERSE_GUARD_EN to reject 180-degree turns
module snake_dir_ctrl
    import snake_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       dir_chg,
    output logic       key_drop,
    output logic [1:0] q_cnt
);

    logic key_any;
    dir_t cand;
    dir_t ref_dir;
    dir_t q_head;
    dir_t q_tail;
    logic q_pop;
    logic q_push;
    logic rej_dup;
    logic rej_full;
    logic rej_opp;
    logic reject;

    // Resolve same-cycle presses by fixed priority; losers are silently ignored
    always_comb begin
        key_any = 1'b1;
        cand    = DIR_UP;
        if (key_up)         cand = DIR_UP;
        else if (key_down)  cand = DIR_DOWN;
        else if (key_left)  cand = DIR_LEFT;
        else if (key_right) cand = DIR_RIGHT;
        else                key_any = 1'b0;
    end

    // A new key is judged against the last queued command, or the live heading when nothing is queued
    assign ref_dir  = (q_cnt != 2'd0) ? q_tail : dir;
    assign q_pop    = tick && (q_cnt != 2'd0);
    assign rej_dup  = (cand == ref_dir);
    assign rej_full = (q_cnt == 2'd2) && !q_pop;

`ifdef SNAKE_REVERSE_GUARD_EN
    assign rej_opp  = is_opposite(cand, ref_dir);
`else
    assign rej_opp  = 1'b0;
`endif

    assign reject = rej_dup || rej_full || rej_opp;
    assign q_push = key_any && !reject;

    snake_cmd_fifo2 u_cmd_fifo (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (q_push),
        .push_data (cand),
        .pop       (q_pop),
        .head      (q_head),
        .tail      (q_tail),
        .count     (q_cnt)
    );

    // Apply the queue head on a tick and register the one-cycle status pulses
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dir      <= DIR_RESET;
            dir_chg  <= 1'b0;
            key_drop <= 1'b0;
        end else begin
            dir_chg  <= q_pop;
            key_drop <= key_any && reject;
            if (q_pop) dir <= q_head;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - self-checking bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       key_up, key_down, key_left, key_right, tick;
    logic [1:0] dir;
    logic       dir_chg;
    logic       key_drop;
    logic [1:0] q_cnt;

    always #10 Clk = ~Clk;

    snake_dir_ctrl dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .tick      (tick),
        .dir       (dir),
        .dir_chg   (dir_chg),
        .key_drop  (key_drop),
        .q_cnt     (q_cnt)
    );

    typedef struct packed {
        logic [1:0] dir;
        logic       chg;
        logic       drop;
        logic [1:0] cnt;
    } exp_t;

    typedef struct {
        bit         rst;
        logic [4:0] k;
        exp_t       e;
    } vec_t;

    localparam logic [4:0] K0 = 5'b00000;
    localparam logic [4:0] KU = 5'b10000;
    localparam logic [4:0] KD = 5'b01000;
    localparam logic [4:0] KL = 5'b00100;
    localparam logic [4:0] KR = 5'b00010;
    localparam logic [4:0] KT = 5'b00001;

`ifdef SNAKE_REVERSE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [4:0] k, logic [1:0] d, logic c, logic dr, logic [1:0] n);
        vec_t v;
        v.rst = rst;
        v.k   = k;
        v.e   = '{dir: d, chg: c, drop: dr, cnt: n};
        return v;
    endfunction

    task automatic check(input string name, input exp_t req);
        exp_t act;
        act = '{dir: dir, chg: dir_chg, drop: key_drop, cnt: q_cnt};
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got dir=%b chg=%b drop=%b cnt=%0d, required dir=%b chg=%b drop=%b cnt=%0d",
                     name, act.dir, act.chg, act.drop, act.cnt, req.dir, req.chg, req.drop, req.cnt);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge Clk);
        Rst_n = 1'b0;
        {key_up, key_down, key_left, key_right, tick} = K0;
        #1;
        check(name, '{dir: 2'b11, chg: 1'b0, drop: 1'b0, cnt: 2'd0});
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic cycle(input logic [4:0] k, input exp_t e, input string name);
        exp_t x;
        @(negedge Clk);
        {key_up, key_down, key_left, key_right, tick} = k;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        {key_up, key_down, key_left, key_right, tick} = K0;
        x = sb.pop_front();
        check(name, x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n = 1'b1;
        {key_up, key_down, key_left, key_right, tick} = K0;

        // reset release then tick with empty queue
        tbl.push_back(mk(1, K0, 2'b11, 0, 0, 2'd0));
        tbl.push_back(mk(0, KT, 2'b11, 0, 0, 2'd0));
        // key_up, tick five cycles later
        tbl.push_back(mk(0, KU, 2'b11, 0, 0, 2'd1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, K0, 2'b11, 0, 0, 2'd1));
        tbl.push_back(mk(0, KT, 2'b00, 1, 0, 2'd0));
        tbl.push_back(mk(0, K0, 2'b00, 0, 0, 2'd0));
        // left beats right when pressed together; left is not opposite of up
        tbl.push_back(mk(0, KL | KR, 2'b00, 0, 0, 2'd1));
        // fill queue, third key dropped, drain in order
        tbl.push_back(mk(1, K0, 2'b11, 0, 0, 2'd0));
        tbl.push_back(mk(0, KU, 2'b11, 0, 0, 2'd1));
        tbl.push_back(mk(0, KL, 2'b11, 0, 0, 2'd2));
        tbl.push_back(mk(0, KD, 2'b11, 0, 1, 2'd2));
        tbl.push_back(mk(0, K0, 2'b11, 0, 0, 2'd2));
        tbl.push_back(mk(0, KT, 2'b00, 1, 0, 2'd1));
        tbl.push_back(mk(0, KT, 2'b10, 1, 0, 2'd0));
        tbl.push_back(mk(0, K0, 2'b10, 0, 0, 2'd0));
        // priority up over right, duplicate of tail, reference is tail not dir
        tbl.push_back(mk(1, K0, 2'b11, 0, 0, 2'd0));
        tbl.push_back(mk(0, KU | KR, 2'b11, 0, 0, 2'd1));
        tbl.push_back(mk(0, KU, 2'b11, 0, 1, 2'd1));
        tbl.push_back(mk(0, KR, 2'b11, 0, 0, 2'd2));
        tbl.push_back(mk(0, K0, 2'b11, 0, 0, 2'd2));
        // duplicate of dir when empty; opposite turn depends on guard
        tbl.push_back(mk(1, K0, 2'b11, 0, 0, 2'd0));
        tbl.push_back(mk(0, KR, 2'b11, 0, 1, 2'd0));
        if (GUARD) begin
            tbl.push_back(mk(0, KL, 2'b11, 0, 1, 2'd0));
            tbl.push_back(mk(0, KT, 2'b11, 0, 0, 2'd0));
        end else begin
            tbl.push_back(mk(0, KL, 2'b11, 0, 0, 2'd1));
            tbl.push_back(mk(0, KT, 2'b10, 1, 0, 2'd0));
        end
        // tick and key together while empty: queued, applied on next tick
        tbl.push_back(mk(1, K0, 2'b11, 0, 0, 2'd0));
        tbl.push_back(mk(0, KT | KU, 2'b11, 0, 0, 2'd1));
        tbl.push_back(mk(0, K0, 2'b11, 0, 0, 2'd1));
        tbl.push_back(mk(0, KT, 2'b00, 1, 0, 2'd0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset($sformatf("vec%0d_reset", i));
            else            cycle(tbl[i].k, tbl[i].e, $sformatf("vec%0d", i));
        end

        // full queue with simultaneous tick and key, then reset mid-operation
        do_reset("seq_full_reset");
        cycle(KU, '{dir: 2'b11, chg: 1'b0, drop: 1'b0, cnt: 2'd1}, "seq_full_up");
        cycle(KL, '{dir: 2'b11, chg: 1'b0, drop: 1'b0, cnt: 2'd2}, "seq_full_left");
        if (GUARD) begin
            cycle(KT | KR, '{dir: 2'b00, chg: 1'b1, drop: 1'b1, cnt: 2'd1}, "seq_full_tick_right");
            cycle(KT,      '{dir: 2'b10, chg: 1'b1, drop: 1'b0, cnt: 2'd0}, "seq_full_tick2");
        end else begin
            cycle(KT | KR, '{dir: 2'b00, chg: 1'b1, drop: 1'b0, cnt: 2'd2}, "seq_full_tick_right");
            cycle(KT,      '{dir: 2'b10, chg: 1'b1, drop: 1'b0, cnt: 2'd1}, "seq_full_tick2");
        end
        do_reset("seq_midop_reset");
        cycle(K0, '{dir: 2'b11, chg: 1'b0, drop: 1'b0, cnt: 2'd0}, "seq_after_release");
        cycle(KT, '{dir: 2'b11, chg: 1'b0, drop: 1'b0, cnt: 2'd0}, "seq_tick_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
